ibex_rvfi_trace_fifo: RTL and testbench

- Parametrised successor to the per-core RVFI tracing path. Captures retirement records from the RISC-V Formal Interface into an on-chip buffer instead of a simulation-only log, so it works in synthesised lockstep builds.
- Supports three capture modes: stop-on-full, ring overwrite, and post-trigger freeze.
- Records drain through a valid/ready port to a debug or DMA master.
- Instantiated one per core next to the core, fed from its rvfi_* outputs.

---
 rtl/ibex_rvfi_trace_fifo.sv | 176 +++++++++++++++++
 tb/tb_ibex_rvfi_trace_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_fifo.sv
// RVFI retirement trace buffer with stop-on-full,
// ring-overwrite and post-trigger freeze capture.
module ibex_rvfi_trace_fifo #(
  parameter int unsigned Depth         = 16,
  parameter int unsigned PostTrigCount = 8,
  parameter int unsigned DropCntW      = 16,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                setback_i,
  input  logic [1:0]          mode_i,
  input  logic                arm_i,
  input  logic                trig_i,
  input  logic                rvfi_valid,
  input  logic                rvfi_trap,
  input  logic                rvfi_intr,
  input  logic [1:0]          rvfi_mode,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  input  logic [31:0]         rvfi_pc_rdata,
  input  logic [31:0]         rvfi_insn,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [104:0]        out_record_o,
  output logic [CntW-1:0]     count_o,
  output logic [DropCntW-1:0] drop_cnt_o,
  output logic [1:0]          state_o,
  output logic                frozen_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  typedef struct packed {
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
  } rec_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StPost   = 2'd2,
    StFrozen = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [PtrW-1:0] post_q, post_d;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic [DropCntW-1:0] drop_q;
  rec_t            mem [Depth];
  rec_t            wr_rec;

  logic capture, pop, full;
  logic push_ok, overwrite, drop;

  assign wr_rec = {rvfi_trap, rvfi_intr,
                   rvfi_mode, rvfi_rd_addr,
                   rvfi_pc_rdata, rvfi_insn,
                   rvfi_rd_wdata};

  assign capture = rvfi_valid &&
                   (state_q == StArmed ||
                    state_q == StPost);
  assign out_valid_o = (count_q != '0);
  assign pop  = out_valid_o && out_ready_i;
  assign full = (count_q == CntW'(Depth));

  // A pop in the same cycle always frees a slot.
  assign push_ok   = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign overwrite = drop && (mode_q != 2'd0);

  assign out_record_o = out_valid_o ?
                        mem[rptr_q] : '0;
  assign count_o    = count_q;
  assign drop_cnt_o = drop_q;
  assign state_o    = state_q;
  assign frozen_o   = (state_q == StFrozen);

  // Capture-control next state; mode 3 folds to 0.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    post_d  = post_q;
    unique case (state_q)
      StIdle, StFrozen: begin
        if (arm_i) begin
          state_d = StArmed;
          mode_d  = (mode_i == 2'd3) ?
                    2'd0 : mode_i;
        end
      end
      StArmed: begin
        if (mode_q == 2'd2 && trig_i) begin
          if (PostTrigCount == 0) begin
            state_d = StFrozen;
          end else begin
            state_d = StPost;
            post_d  = PtrW'(PostTrigCount);
          end
        end
      end
      StPost: begin
        if (capture) begin
          post_d = post_q - PtrW'(1);
          if (post_q == PtrW'(1)) begin
            state_d = StFrozen;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      post_q  <= '0;
    end else if (setback_i) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      post_q  <= post_d;
    end
  end

  // Pointers, occupancy and saturating drop count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else if (setback_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push_ok || overwrite) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop || overwrite) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CntW'(1);
      end
      if (drop && drop_q != '1) begin
        drop_q <= drop_q + DropCntW'(1);
      end
    end
  end

  // Record storage; contents masked when empty.
  always_ff @(posedge clk_i) begin
    if (!setback_i && (push_ok || overwrite)) begin
      mem[wptr_q] <= wr_rec;
    end
  end

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
// Randomised and directed bench for the RVFI
// trace FIFO against a queue-based model.
module tb_ibex_rvfi_trace_fifo;

  localparam int Depth = 16;
  localparam int Ptc   = 8;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         setback = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         arm = 1'b0;
  logic         trig = 1'b0;
  logic         valid = 1'b0;
  logic         trap = 1'b0;
  logic         intr = 1'b0;
  logic [1:0]   pmode = 2'd0;
  logic [4:0]   rd = 5'd0;
  logic [31:0]  wdata = 32'd0;
  logic [31:0]  pc = 32'd0;
  logic [31:0]  insn = 32'd0;
  logic         ready = 1'b0;

  logic         o_valid;
  logic [104:0] o_rec;
  logic [4:0]   o_cnt;
  logic [15:0]  o_drop;
  logic [1:0]   o_state;
  logic         o_frozen;

  logic         z_valid;
  logic [104:0] z_rec;
  logic [4:0]   z_cnt;
  logic [15:0]  z_drop;
  logic [1:0]   z_state;
  logic         z_frozen;

  int checks = 0;
  int failures = 0;

  logic [104:0] q[$];
  int           m_st = 0;
  int           m_md = 0;
  int           m_pc = 0;
  int unsigned  m_drop = 0;

  always #5 clk = ~clk;

  ibex_rvfi_trace_fifo #(
    .Depth(Depth), .PostTrigCount(Ptc),
    .DropCntW(16)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .setback_i(setback), .mode_i(mode),
    .arm_i(arm), .trig_i(trig),
    .rvfi_valid(valid), .rvfi_trap(trap),
    .rvfi_intr(intr), .rvfi_mode(pmode),
    .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata),
    .rvfi_pc_rdata(pc), .rvfi_insn(insn),
    .out_valid_o(o_valid), .out_ready_i(ready),
    .out_record_o(o_rec), .count_o(o_cnt),
    .drop_cnt_o(o_drop), .state_o(o_state),
    .frozen_o(o_frozen)
  );

  ibex_rvfi_trace_fifo #(
    .Depth(Depth), .PostTrigCount(0),
    .DropCntW(16)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .setback_i(setback), .mode_i(mode),
    .arm_i(arm), .trig_i(trig),
    .rvfi_valid(valid), .rvfi_trap(trap),
    .rvfi_intr(intr), .rvfi_mode(pmode),
    .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata),
    .rvfi_pc_rdata(pc), .rvfi_insn(insn),
    .out_valid_o(z_valid), .out_ready_i(ready),
    .out_record_o(z_rec), .count_o(z_cnt),
    .drop_cnt_o(z_drop), .state_o(z_state),
    .frozen_o(z_frozen)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    q.delete();
    m_st = 0;
    m_md = 0;
    m_pc = 0;
    m_drop = 0;
  endfunction

  function automatic void m_step();
    logic [104:0] r;
    bit cap, pp;
    int sz;
    if (setback) begin
      m_clear();
      return;
    end
    r = {trap, intr, pmode, rd, pc, insn, wdata};
    cap = valid && (m_st == 1 || m_st == 2);
    sz = q.size();
    pp = (sz > 0) && ready;
    if (pp) void'(q.pop_front());
    if (cap) begin
      if (sz < Depth || pp) begin
        q.push_back(r);
      end else begin
        if (m_drop < 65535) m_drop++;
        if (m_md != 0) begin
          void'(q.pop_front());
          q.push_back(r);
        end
      end
    end
    case (m_st)
      0, 3: if (arm) begin
        m_st = 1;
        m_md = (mode == 3) ? 0 : int'(mode);
      end
      1: if (m_md == 2 && trig) begin
        m_st = 2;
        m_pc = Ptc;
      end
      2: if (cap) begin
        m_pc--;
        if (m_pc == 0) m_st = 3;
      end
      default: m_st = 0;
    endcase
  endfunction

  task automatic cmp_all();
    logic [104:0] er;
    er = (q.size() > 0) ? q[0] : '0;
    chk("count", o_cnt, q.size());
    chk("valid", o_valid, q.size() > 0);
    chk("drop", o_drop, m_drop);
    chk("state", o_state, m_st);
    chk("frozen", o_frozen, m_st == 3);
    chk("record", o_rec, er);
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    cmp_all();
  endtask

  task automatic rnd_fields();
    trap  = 1'($urandom);
    intr  = 1'($urandom);
    pmode = 2'($urandom);
    rd    = 5'($urandom);
    wdata = $urandom;
    insn  = $urandom;
  endtask

  task automatic retire(input logic [31:0] p);
    rnd_fields();
    pc = p;
    valid = 1'b1;
    cycle();
    valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] md);
    mode = md;
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  task automatic do_setback();
    setback = 1'b1;
    cycle();
    setback = 1'b0;
  endtask

  initial begin
    m_clear();
    #12;
    chk("rst_cnt", o_cnt, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_state", o_state, 0);
    chk("rst_rec", o_rec, 0);
    rst_ni = 1'b1;

    do_arm(2'd0);
    retire(32'h100);
    retire(32'h104);
    retire(32'h108);
    chk("a_cnt", o_cnt, 3);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("a_pc", o_rec[95:64], 32'h100 + 4 * i);
      cycle();
    end
    chk("a_empty", o_valid, 0);
    ready = 1'b0;

    do_setback();
    do_arm(2'd0);
    for (int i = 0; i < 20; i++)
      retire(32'h1000 + 4 * i);
    chk("b_cnt", o_cnt, 16);
    chk("b_drop", o_drop, 4);
    chk("b_head", o_rec[95:64], 32'h1000);

    do_setback();
    do_arm(2'd1);
    for (int i = 0; i < 20; i++)
      retire(32'h2000 + 4 * i);
    chk("c_cnt", o_cnt, 16);
    chk("c_drop", o_drop, 4);
    chk("c_head", o_rec[95:64], 32'h2010);
    ready = 1'b1;
    retire(32'h2100);
    ready = 1'b0;
    chk("c_pp_drop", o_drop, 4);
    chk("c_pp_cnt", o_cnt, 16);

    do_setback();
    do_arm(2'd2);
    for (int i = 1; i <= 30; i++) begin
      trig = (i == 20);
      retire(32'h3000 + 4 * i);
      trig = 1'b0;
      if (i == 27) chk("d_post", o_state, 2);
      if (i == 28) chk("d_frz", o_frozen, 1);
    end
    chk("d_cnt", o_cnt, 16);
    chk("d_head", o_rec[95:64], 32'h3000 + 4 * 13);
    ready = 1'b1;
    for (int i = 13; i <= 28; i++) begin
      chk("d_pc", o_rec[95:64], 32'h3000 + 4 * i);
      cycle();
    end
    ready = 1'b0;
    chk("d_empty", o_valid, 0);

    do_setback();
    do_arm(2'd2);
    trig = 1'b1;
    cycle();
    trig = 1'b0;
    chk("e_frz", z_state, 3);
    chk("e_frzo", z_frozen, 1);
    mode = 2'd2;
    arm = 1'b1;
    cycle();
    arm = 1'b0;
    chk("e_rearm", z_state, 1);
    retire(32'h4000);
    chk("e_cap", z_cnt, 1);
    chk("e_pc", z_rec[95:64], 32'h4000);

    do_setback();
    do_arm(2'd2);
    for (int i = 0; i < 9; i++)
      retire(32'h5000 + 4 * i);
    trig = 1'b1;
    retire(32'h5100);
    trig = 1'b0;
    chk("f_cnt", o_cnt, 10);
    chk("f_st", o_state, 2);
    do_setback();
    chk("f_sb_cnt", o_cnt, 0);
    chk("f_sb_st", o_state, 0);
    chk("f_sb_drop", o_drop, 0);

    do_arm(2'd1);
    for (int i = 0; i < 18; i++)
      retire(32'h6000 + 4 * i);
    #2;
    rst_ni = 1'b0;
    #1;
    m_clear();
    chk("g_cnt", o_cnt, 0);
    chk("g_valid", o_valid, 0);
    chk("g_drop", o_drop, 0);
    chk("g_st", o_state, 0);
    chk("g_rec", o_rec, 0);
    #1;
    rst_ni = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      setback = ($urandom_range(0, 99) == 0);
      arm   = ($urandom_range(0, 19) == 0);
      mode  = 2'($urandom);
      trig  = ($urandom_range(0, 15) == 0);
      valid = 1'($urandom);
      ready = ($urandom_range(0, 3) == 0);
      rnd_fields();
      pc = $urandom;
      cycle();
    end
    setback = 1'b0;
    arm = 1'b0;
    trig = 1'b0;
    valid = 1'b0;
    ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
